uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte presented with the receiver's one-cycle done tick. Captured bytes are held in order until the consuming logic (processor or loader) pops them with a read strobe. It decouples the bursty serial byte arrival from the consumer and reports lost bytes through a sticky overrun flag.

---
 rtl/uart_rx_fifo_pkg.sv | 13 +
 rtl/uart_fifo_mem.sv | 22 ++
 rtl/uart_rx_fifo.sv | 96 +++++++++
 tb/tb_uart_rx_fifo.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: byte width, default receive FIFO depth and FIFO operation encoding.
package uart_rx_fifo_pkg;
    localparam int UART_DATA_W    = 8;
    localparam int RX_FIFO_ADDR_W = 4;

    // Encoding of {write accepted, read accepted} for the pointer/flag update.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_RD    = 2'b01,
        OP_WR    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_e;
endpackage

// File: rtl/uart_fifo_mem.sv
// Register file, 2**ADDR_W x DATA_W: synchronous write port, asynchronous read port.
// Latency: write visible on rdata after the write edge; no backpressure, caller gates we.
// Storage is intentionally unreset.
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO (first-word-fall-through) with sticky overrun; UART_RX_FIFO_CNT_EN adds count.
// Latency: a written byte shows on dout one edge later; a pop exposes the next entry one edge later.
// Backpressure: none toward the receiver -- writes while full are dropped and set overrun.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = RX_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              overrun,
`ifdef UART_RX_FIFO_CNT_EN
    output logic [ADDR_W:0]   count,
`endif
    input  logic              clr_ovr
);
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] wr_ptr_inc, rd_ptr_inc;
    logic              rd_acc, wr_acc, drop;
    fifo_op_e          op;

    // A pop on a full FIFO frees the slot the incoming byte lands in.
    assign rd_acc     = rd && !empty;
    assign wr_acc     = wr && (!full || rd);
    assign drop       = wr && full && !rd;
    assign op         = fifo_op_e'({wr_acc, rd_acc});
    assign wr_ptr_inc = wr_ptr + ADDR_W'(1);
    assign rd_ptr_inc = rd_ptr + ADDR_W'(1);

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            case (op)
                OP_WR: begin
                    wr_ptr <= wr_ptr_inc;
                    empty  <= 1'b0;
                    if (wr_ptr_inc == rd_ptr) full <= 1'b1;
                end
                OP_RD: begin
                    rd_ptr <= rd_ptr_inc;
                    full   <= 1'b0;
                    if (rd_ptr_inc == wr_ptr) empty <= 1'b1;
                end
                OP_WR_RD: begin
                    wr_ptr <= wr_ptr_inc;
                    rd_ptr <= rd_ptr_inc;
                end
                default: ;
            endcase
        end
    end

    // A drop on the same edge as clr_ovr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overrun <= 1'b0;
        else if (drop)    overrun <= 1'b1;
        else if (clr_ovr) overrun <= 1'b0;
    end

`ifdef UART_RX_FIFO_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case (op)
                OP_WR:   count <= count + (ADDR_W+1)'(1);
                OP_RD:   count <= count - (ADDR_W+1)'(1);
                default: ;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (default depth 16); count checked when UART_RX_FIFO_CNT_EN is defined.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd = 1'b0;
    logic       clr_ovr = 1'b0;
    logic [7:0] dout;
    logic       empty, full, overrun;
`ifdef UART_RX_FIFO_CNT_EN
    logic [4:0] count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (wr),
        .din     (din),
        .rd      (rd),
        .dout    (dout),
        .empty   (empty),
        .full    (full),
        .overrun (overrun),
`ifdef UART_RX_FIFO_CNT_EN
        .count   (count),
`endif
        .clr_ovr (clr_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr = 1'b1; din = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovr", 32'(overrun), 0);
`ifdef UART_RX_FIFO_CNT_EN
        chk("rst_count", 32'(count), 0);
`endif
        pop();
        chk("rd_empty_ignored", 32'(empty), 1);
        chk("rd_empty_full", 32'(full), 0);

        push(8'h55);
        chk("single_empty", 32'(empty), 0);
        chk("single_dout", 32'(dout), 32'h55);
        pop();
        chk("single_drain", 32'(empty), 1);

        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            chk("fill_full", 32'(full), (i == 15) ? 1 : 0);
        end
`ifdef UART_RX_FIFO_CNT_EN
        chk("full_count", 32'(count), 16);
`endif
        push(8'hAA);
        chk("drop_ovr", 32'(overrun), 1);
        chk("drop_head", 32'(dout), 32'h00);
        chk("drop_full", 32'(full), 1);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        chk("clr_ovr", 32'(overrun), 0);
        clr_ovr = 1'b1; push(8'hAA); clr_ovr = 1'b0;
        chk("drop_vs_clr", 32'(overrun), 1);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        chk("clr_ovr2", 32'(overrun), 0);

        wr = 1'b1; din = 8'hBB; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        chk("wrrd_full", 32'(full), 1);
        chk("wrrd_head", 32'(dout), 32'h01);
        for (int i = 1; i <= 16; i++) begin
            chk("order1", 32'(dout), (i == 16) ? 32'hBB : 32'(i));
            pop();
        end
        chk("order1_empty", 32'(empty), 1);
        pop();
        chk("rd_empty_again", 32'(empty), 1);

        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        chk("pass2_full", 32'(full), 1);
        for (int i = 0; i < 16; i++) begin
            chk("order2", 32'(dout), 32'h20 + 32'(i));
            pop();
        end
        chk("pass2_empty", 32'(empty), 1);
        chk("pass2_notfull", 32'(full), 0);

        wr = 1'b1; din = 8'h3C; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        chk("wrrd_empty", 32'(empty), 0);
        chk("wrrd_dout", 32'(dout), 32'h3C);
`ifdef UART_RX_FIFO_CNT_EN
        chk("wrrd_count", 32'(count), 1);
`endif
        pop();
        chk("wrrd_drain", 32'(empty), 1);

        for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
        chk("burst_empty", 32'(empty), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_empty", 32'(empty), 1);
        chk("async_rst_full", 32'(full), 0);
`ifdef UART_RX_FIFO_CNT_EN
        chk("async_rst_count", 32'(count), 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_empty", 32'(empty), 1);
        push(8'h99);
        chk("post_rst_dout", 32'(dout), 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
